// File: rtl/deal_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : deal_arbiter_if
//  Description : Bundles the sequencer strobes, shoe handshake and slot write
//                bus around the deal arbiter. The arbiter connects through the
//                slave modport; the surrounding sequencer/shoe/slot logic
//                (or a testbench) connects through the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface deal_arbiter_if;
    // Sequencer side
    logic [5:0] load_req;      // {pcard1,pcard2,pcard3,dcard1,dcard2,dcard3}
    logic       round_done;
    logic       deal_busy;
    logic       shuffle_busy;

    // Shoe handshake
    logic       card_req;
    logic       card_ack;
    logic [3:0] card_in;

    // Slot register write bus
    logic [3:0] card_out;
    logic [5:0] card_we;

    // Status
    logic [8:0] draws_left;
    logic [2:0] err_flags;     // sticky {timeout, bad_card, overlap}

    modport master (
        output load_req,
        output round_done,
        output card_ack,
        output card_in,
        input  card_req,
        input  card_out,
        input  card_we,
        input  deal_busy,
        input  shuffle_busy,
        input  draws_left,
        input  err_flags
    );

    modport slave (
        input  load_req,
        input  round_done,
        input  card_ack,
        input  card_in,
        output card_req,
        output card_out,
        output card_we,
        output deal_busy,
        output shuffle_busy,
        output draws_left,
        output err_flags
    );
endinterface
`default_nettype wire

// File: rtl/deal_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : deal_arbiter
//  Description : Owns the card shoe. Queues one-hot slot load strobes, serves
//                them highest bit first through a req/ack handshake with the
//                shoe, writes each card into its slot, counts cards left and
//                runs a fixed-length reshuffle at the cut point or when the
//                shoe runs dry with work pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module deal_arbiter #(
    parameter int NUM_DECKS      = 1,
    parameter int CUT_MARGIN     = 16,
    parameter int SHUFFLE_CYCLES = 64,
    parameter int ACK_TIMEOUT    = 15
) (
    input  wire logic     slow_clock,
    input  wire logic     reset,
    deal_arbiter_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int c_SHUF_W = $clog2(SHUFFLE_CYCLES + 1);

    localparam logic [8:0]          c_FULL_SHOE = 9'(52 * NUM_DECKS);
    localparam logic [8:0]          c_CUT       = 9'(CUT_MARGIN);
    // Last REQ cycle index before a timeout fires (counter starts at 0).
    localparam logic [c_WAIT_W-1:0] c_ACK_LAST  = c_WAIT_W'(ACK_TIMEOUT - 1);
    // Last SHUFFLE cycle index (counter starts at 0).
    localparam logic [c_SHUF_W-1:0] c_SHUF_LAST = c_SHUF_W'(SHUFFLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WRITE   = 2'd2,
        SHUFFLE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [5:0]          r_pending;
    logic [5:0]          r_target;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_SHUF_W-1:0] r_shuf_cnt;
    logic [8:0]          r_draws_left;
    logic                r_card_req;
    logic [5:0]          r_card_we;
    logic [3:0]          r_card_out;
    logic                r_shuffle_busy;
    logic [2:0]          r_err;
    logic                r_armed;
    logic                r_round_seen;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [5:0] w_sel;
    logic [5:0] w_pend_in;
    logic       w_overlap;
    logic       w_card_ok;
    logic [8:0] w_draws_dec;

    // Highest set pending bit wins (bit5 = pcard1 first).
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < 6; i++) begin
            if (r_pending[i]) begin
                w_sel = 6'd1 << i;
            end
        end
    end

    assign w_pend_in   = r_pending | bus.load_req;
    assign w_overlap   = |(r_pending & bus.load_req);
    assign w_card_ok   = (bus.card_in != 4'd0) && (bus.card_in <= 4'd13);
    assign w_draws_dec = (r_draws_left != 9'd0) ? (r_draws_left - 9'd1) : 9'd0;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs. Slot write side effects (card_we,
    // card_out, draws_left, pending clear) are applied on the edge entering
    // WRITE so they are all visible together during the WRITE cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pending      <= '0;
            r_target       <= '0;
            r_wait_cnt     <= '0;
            r_shuf_cnt     <= '0;
            r_draws_left   <= c_FULL_SHOE;
            r_card_req     <= 1'b0;
            r_card_we      <= '0;
            r_card_out     <= '0;
            r_shuffle_busy <= 1'b0;
            r_err          <= '0;
            r_armed        <= 1'b0;
            r_round_seen   <= 1'b0;
        end else begin
            // Strobes accumulate in every state; a repeat of a queued slot is
            // flagged and merged, so the slot is still served only once.
            r_pending <= w_pend_in;
            if (w_overlap) begin
                r_err[0] <= 1'b1;
            end
            if (r_armed && bus.round_done) begin
                r_round_seen <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if ((r_pending != 6'd0) && (r_draws_left == 9'd0)) begin
                        // Shoe is empty but slots still need cards.
                        r_state        <= SHUFFLE;
                        r_shuffle_busy <= 1'b1;
                        r_shuf_cnt     <= '0;
                    end else if (r_pending != 6'd0) begin
                        r_target   <= w_sel;
                        r_state    <= REQ;
                        r_card_req <= 1'b1;
                        r_wait_cnt <= '0;
                    end else if (r_armed && r_round_seen) begin
                        r_state        <= SHUFFLE;
                        r_shuffle_busy <= 1'b1;
                        r_shuf_cnt     <= '0;
                    end
                end

                REQ: begin
                    if (bus.card_ack && w_card_ok) begin
                        r_state      <= WRITE;
                        r_card_req   <= 1'b0;
                        r_card_we    <= r_target;
                        r_card_out   <= bus.card_in;
                        r_pending    <= w_pend_in & ~r_target;
                        r_draws_left <= w_draws_dec;
                        if (w_draws_dec <= c_CUT) begin
                            r_armed <= 1'b1;
                        end
                    end else if (bus.card_ack) begin
                        // Illegal rank: keep asking, give the shoe a fresh window.
                        r_err[1]   <= 1'b1;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_ACK_LAST) begin
                        // Give up on this slot; nothing is written.
                        r_err[2]   <= 1'b1;
                        r_pending  <= w_pend_in & ~r_target;
                        r_card_req <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end

                WRITE: begin
                    // r_pending already excludes the slot just written.
                    r_card_we <= '0;
                    if ((r_pending != 6'd0) && (r_draws_left == 9'd0)) begin
                        // Never request from an empty shoe.
                        r_state        <= SHUFFLE;
                        r_shuffle_busy <= 1'b1;
                        r_shuf_cnt     <= '0;
                    end else if (r_pending != 6'd0) begin
                        r_target   <= w_sel;
                        r_state    <= REQ;
                        r_card_req <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                SHUFFLE: begin
                    if (r_shuf_cnt == c_SHUF_LAST) begin
                        r_state        <= IDLE;
                        r_shuffle_busy <= 1'b0;
                        r_draws_left   <= c_FULL_SHOE;
                        r_armed        <= 1'b0;
                        r_round_seen   <= 1'b0;
                    end else begin
                        r_shuf_cnt <= r_shuf_cnt + c_SHUF_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.card_req     = r_card_req;
    assign bus.card_we      = r_card_we;
    assign bus.card_out     = r_card_out;
    assign bus.shuffle_busy = r_shuffle_busy;
    assign bus.draws_left   = r_draws_left;
    assign bus.err_flags    = r_err;
    // Decoded from registers only: rises the cycle after the first strobe.
    assign bus.deal_busy    = (r_pending != 6'd0) || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_deal_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_deal_arbiter
//  Description : Self-checking bench for deal_arbiter. A behavioural shoe
//                answers requests with random or scripted cards; a
//                transaction-level model predicts the order of slot writes,
//                their card values, the remaining-card count and reshuffles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deal_arbiter;
    localparam int c_FULL = 52;
    localparam int c_CUT  = 16;
    localparam int c_SHUF = 64;
    localparam int c_TMO  = 15;

    logic slow_clock = 1'b0;
    logic reset;

    deal_arbiter_if bus();

    deal_arbiter #(
        .NUM_DECKS      (1),
        .CUT_MARGIN     (c_CUT),
        .SHUFFLE_CYCLES (c_SHUF),
        .ACK_TIMEOUT    (c_TMO)
    ) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus        (bus.slave)
    );

    always #5 slow_clock = ~slow_clock;

    // Bookkeeping
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int m_draws = c_FULL;
    int n_writes = 0;
    int n_shuffles = 0;
    int n_bad = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;
    int strobe_cyc = 0;
    bit shoe_en = 1'b1;
    bit bad_en = 1'b0;
    int max_delay = 0;
    logic [5:0] exp_slots[$];   // slots expected to be written, in order
    int card_q[$];              // valid cards handed out, in order
    int forced[$];              // scripted shoe answers

    int n, len, k, w0, s0, bad0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_card_req"},     bus.card_req, 0);
        check({tag, "_card_we"},      bus.card_we, 0);
        check({tag, "_card_out"},     bus.card_out, 0);
        check({tag, "_shuffle_busy"}, bus.shuffle_busy, 0);
        check({tag, "_err_flags"},    bus.err_flags, 0);
        check({tag, "_draws_left"},   bus.draws_left, c_FULL);
        check({tag, "_deal_busy"},    bus.deal_busy, 0);
    endtask

    // One-cycle strobe; optionally queue the expected writes (highest bit first).
    task automatic strobe(input logic [5:0] mask, input bit expect_service);
        @(negedge slow_clock);
        bus.load_req = mask;
        strobe_cyc   = cyc;
        if (expect_service) begin
            for (int i = 5; i >= 0; i--) begin
                if (mask[i]) exp_slots.push_back(6'd1 << i);
            end
        end
        @(negedge slow_clock);
        bus.load_req = '0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int t;
        t = 0;
        while ((bus.deal_busy || bus.shuffle_busy) && t < budget) begin
            @(negedge slow_clock);
            t++;
        end
        check({tag, "_idle"}, (bus.deal_busy || bus.shuffle_busy), 0);
        check({tag, "_all_served"}, exp_slots.size(), 0);
    endtask

    always @(posedge slow_clock) cyc <= cyc + 1;

    // Behavioural shoe: answers a pending request after a random delay.
    initial begin : shoe
        int wait_left;
        int v;
        wait_left = 0;
        bus.card_ack = 1'b0;
        bus.card_in  = '0;
        forever begin
            @(negedge slow_clock);
            bus.card_ack = 1'b0;
            if (shoe_en && bus.card_req === 1'b1) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    if (forced.size() != 0)
                        v = forced.pop_front();
                    else if (bad_en && $urandom_range(0, 7) == 0)
                        v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(14, 15));
                    else
                        v = int'($urandom_range(1, 13));
                    bus.card_ack = 1'b1;
                    bus.card_in  = 4'(v);
                    if (v >= 1 && v <= 13) card_q.push_back(v);
                    else n_bad++;
                    wait_left = int'($urandom_range(0, max_delay));
                end
            end
        end
    end

    // Transaction model: checks every slot write and every reshuffle.
    initial begin : monitor
        logic [5:0] es;
        int ec;
        int shuf_len;
        shuf_len = 0;
        forever begin
            @(negedge slow_clock);
            if (reset === 1'b1) begin
                m_draws  = c_FULL;
                shuf_len = 0;
            end else begin
                if (bus.card_we != 6'd0) begin
                    n_writes++;
                    es = (exp_slots.size() != 0) ? exp_slots.pop_front() : 6'd0;
                    check("we_slot", bus.card_we, es);
                    ec = (card_q.size() != 0) ? card_q.pop_front() : -1;
                    check("card_out", bus.card_out, ec);
                    if (m_draws > 0) m_draws--;
                    check("draws_after_write", bus.draws_left, m_draws);
                    prev_wr_cyc = last_wr_cyc;
                    last_wr_cyc = cyc;
                end
                if (bus.card_req === 1'b1)
                    check("req_with_empty_shoe", (bus.draws_left == 9'd0), 0);
                if (bus.shuffle_busy === 1'b1) begin
                    check("req_in_shuffle", bus.card_req, 0);
                    shuf_len++;
                end else if (shuf_len != 0) begin
                    check("shuffle_len", shuf_len, c_SHUF);
                    check("draws_after_shuffle", bus.draws_left, c_FULL);
                    m_draws = c_FULL;
                    n_shuffles++;
                    shuf_len = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

    initial begin : main
        reset          = 1'b1;
        bus.load_req   = '0;
        bus.round_done = 1'b0;
        repeat (2) @(negedge slow_clock);
        check_reset_values("reset");
        reset = 1'b0;

        // Single strobe, immediate ack with a 7: write 3 cycles after strobe.
        forced.push_back(7);
        strobe(6'b100000, 1'b1);
        check("t1_busy_after_strobe", bus.deal_busy, 1);
        wait_idle(50, "t1");
        check("t1_latency", last_wr_cyc - strobe_cyc, 3);
        check("t1_card_out_hold", bus.card_out, 7);
        check("t1_draws", bus.draws_left, 51);

        // Two slots: back-to-back writes, no IDLE bubble.
        strobe(6'b100100, 1'b1);
        wait_idle(50, "t2");
        check("t2_back_to_back", last_wr_cyc - prev_wr_cyc, 2);
        check("t2_draws", bus.draws_left, 49);

        // Silent shoe: timeout after 15 request cycles; repeated strobe overlaps.
        shoe_en = 1'b0;
        @(negedge slow_clock); bus.load_req = 6'b000010;
        @(negedge slow_clock); bus.load_req = 6'b000010;
        @(negedge slow_clock); bus.load_req = '0;
        n = 0;
        while (bus.card_req !== 1'b1 && n < 20) begin @(negedge slow_clock); n++; end
        len = 0;
        while (bus.card_req === 1'b1 && len < 40) begin @(negedge slow_clock); len++; end
        check("t3_req_len", len, c_TMO);
        check("t3_err", bus.err_flags, 3'b101);
        check("t3_not_busy", bus.deal_busy, 0);
        repeat (3) @(negedge slow_clock);
        check("t3_no_retry", bus.card_req, 0);
        check("t3_draws", bus.draws_left, 49);
        shoe_en = 1'b1;

        // Bad rank then a 9: one write of 9, bad-card flag set.
        forced.push_back(0);
        forced.push_back(9);
        w0 = n_writes;
        strobe(6'b000001, 1'b1);
        wait_idle(50, "t4");
        check("t4_writes", n_writes - w0, 1);
        check("t4_card", bus.card_out, 9);
        check("t4_err", bus.err_flags, 3'b111);
        check("t4_draws", bus.draws_left, 48);

        // Deal down to the cut point, then reshuffle on round_done.
        for (int it = 0; it < 20 && m_draws > c_CUT; it++) begin
            k = (m_draws - c_CUT > 6) ? 6 : m_draws - c_CUT;
            strobe(6'((1 << k) - 1), 1'b1);
            wait_idle(200, "t5_deal");
        end
        check("t5_draws_cut", bus.draws_left, c_CUT);
        s0 = n_shuffles;
        @(negedge slow_clock); bus.round_done = 1'b1;
        @(negedge slow_clock); bus.round_done = 1'b0;
        n = 0;
        while (bus.shuffle_busy !== 1'b1 && n < 20) begin @(negedge slow_clock); n++; end
        check("t5_shuffle_start", bus.shuffle_busy, 1);
        strobe(6'b010000, 1'b1);
        check("t5_held_in_shuffle", bus.card_req, 0);
        check("t5_busy_in_shuffle", bus.deal_busy, 1);
        wait_idle(200, "t5");
        check("t5_shuffles", n_shuffles - s0, 1);
        check("t5_draws", bus.draws_left, 51);

        // Drain the shoe with slots still pending: forced reshuffle mid-batch.
        s0 = n_shuffles;
        for (int it = 0; it < 20 && m_draws > 3; it++) begin
            k = (m_draws - 3 > 6) ? 6 : m_draws - 3;
            strobe(6'((1 << k) - 1), 1'b1);
            wait_idle(200, "t6_deal");
        end
        check("t6_draws3", bus.draws_left, 3);
        check("t6_no_early_shuffle", n_shuffles - s0, 0);
        strobe(6'b111111, 1'b1);
        wait_idle(300, "t6");
        check("t6_forced_shuffle", n_shuffles - s0, 1);
        check("t6_draws", bus.draws_left, 49);

        // Reset in the middle of a request.
        shoe_en = 1'b0;
        strobe(6'b000100, 1'b0);
        n = 0;
        while (bus.card_req !== 1'b1 && n < 20) begin @(negedge slow_clock); n++; end
        check("t7_in_req", bus.card_req, 1);
        repeat (3) @(negedge slow_clock);
        reset = 1'b1;
        @(negedge slow_clock);
        check_reset_values("t7");
        @(negedge slow_clock);
        reset   = 1'b0;
        shoe_en = 1'b1;

        // Randomized batches with random shoe delays and occasional bad ranks.
        bad_en = 1'b1;
        bad0   = n_bad;
        for (int b = 0; b < 12; b++) begin
            max_delay = int'($urandom_range(0, 3));
            strobe(6'($urandom_range(1, 63)), 1'b1);
            wait_idle(400, "rand");
        end
        check("rand_err", bus.err_flags, {1'b0, (n_bad != bad0), 1'b0});
        check("rand_draws", bus.draws_left, m_draws);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
